// File: rtl/addsub_pkg.sv
// Shared constants and round-robin helper functions for the add/sub arbiter.
package addsub_pkg;

  localparam int unsigned ADDSUB_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Pointer value after a grant: the requester just served drops to lowest priority.
  function automatic int unsigned rr_next(input int unsigned grant, input int unsigned nreq);
    return (grant + 1 >= nreq) ? 0 : grant + 1;
  endfunction

  // Requester examined at search position 'offset' when starting from 'base'.
  function automatic int unsigned rr_index(input int unsigned base, input int unsigned offset,
                                           input int unsigned nreq);
    return (base + offset) % nreq;
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational W-bit ripple-carry adder/subtractor.
//   a, b : operands
//   sub  : OP_SUB computes a + ~b + 1, OP_ADD computes a + b
//   sum  : two's-complement result
//   cout : carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf  : signed overflow
module addsub_core
  import addsub_pkg::*;
#(
  parameter int unsigned W = ADDSUB_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [W-1:0] w_b_eff;
  logic [W:0]   w_carry;

  assign w_b_eff    = (sub == OP_SUB) ? ~b : b;
  assign w_carry[0] = sub;

  // Bit-level ripple chain.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]       = a[i] ^ w_b_eff[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & w_b_eff[i]) | (w_carry[i] & (a[i] ^ w_b_eff[i]));
  end

  assign cout = w_carry[W];

  // Overflow when operand signs make the result sign impossible.
  assign ovf = (sub == OP_SUB)
             ? ((a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]))
             : ((a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]));

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath among NREQ requesters.
//   clk, rst_n              : clock, synchronous active-low reset
//   req_valid/req_ready     : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b, req_sub   : flattened operands and op select, requester i at [i*W +: W]
//   res_valid/res_ready     : result handshake
//   res_sum/cout/ovf/id     : registered result, flags and originating requester
module addsub_rr_arbiter
  import addsub_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned W    = ADDSUB_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_sum,
  output logic              res_cout,
  output logic              res_ovf,
  output logic [IDW-1:0]    res_id
);

  logic [IDW-1:0] r_ptr;
  logic           r_res_valid;
  logic [W-1:0]   r_res_sum;
  logic           r_res_cout;
  logic           r_res_ovf;
  logic [IDW-1:0] r_res_id;

  logic           w_can_accept;
  logic           w_found;
  logic [IDW-1:0] w_grant;
  logic           w_xfer;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic           w_sub;
  logic [W-1:0]   w_sum;
  logic           w_cout;
  logic           w_ovf;

  // Reset blocks grants so a pending request is not consumed during reset.
  assign w_can_accept = rst_n && (!r_res_valid || res_ready);

  // Priority search starting at the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[IDW'(rr_index(32'(r_ptr), k, NREQ))]) begin
        w_found = 1'b1;
        w_grant = IDW'(rr_index(32'(r_ptr), k, NREQ));
      end
    end
  end

  assign w_xfer = w_can_accept && w_found;

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_grant] = 1'b1;
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_sub = OP_ADD;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_a   = req_a[i*W +: W];
        w_b   = req_b[i*W +: W];
        w_sub = req_sub[i];
      end
    end
  end

  addsub_core #(.W(W)) u_core (
    .a    (w_a),
    .b    (w_b),
    .sub  (w_sub),
    .sum  (w_sum),
    .cout (w_cout),
    .ovf  (w_ovf)
  );

  // Output register: load on transfer, otherwise drain on res_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_ovf   <= 1'b0;
      r_res_id    <= '0;
    end else if (w_xfer) begin
      r_res_valid <= 1'b1;
      r_res_sum   <= w_sum;
      r_res_cout  <= w_cout;
      r_res_ovf   <= w_ovf;
      r_res_id    <= w_grant;
      r_ptr       <= IDW'(rr_next(32'(w_grant), NREQ));
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_cout  = r_res_cout;
  assign res_ovf   = r_res_ovf;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed and randomized self-checking bench for addsub_rr_arbiter.
module tb_addsub_rr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned W    = 32;

  typedef struct packed {
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;
    logic [IDW-1:0] id;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_sum;
  logic              res_cout;
  logic              res_ovf;
  logic [IDW-1:0]    res_id;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t            q[$];
  exp_t            e;
  int              wait_cnt[NREQ];
  logic [NREQ-1:0] hs;
  logic [NREQ-1:0] hs_prev;
  int              g;

  addsub_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_ovf   (res_ovf),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sub[i]      = s;
  endtask

  // Reference result computed with wide signed/unsigned arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int id);
    exp_t   r;
    logic [W:0] full;
    longint sa, sb, sr;
    full = s ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sr   = s ? (sa - sb) : (sa + sb);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.id   = IDW'(id);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h100 * (i + 1), 32'(i), 1'b0);

    // Reset with every requester valid.
    step();
    step();
    smp();
    check("rst_ready", req_ready, 4'b0000);
    check("rst_valid", res_valid, 0);
    check("rst_sum", res_sum, 0);
    check("rst_flags", {res_cout, res_ovf, res_id}, 0);

    // Grants rotate 0,1,2,3,0 once reset releases.
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      smp();
      check("rot_ready", req_ready, 4'b0001 << (c % 4));
      if (c > 0) begin
        check("rot_id", res_id, (c - 1) % 4);
        check("rot_sum", res_sum, 32'h100 * ((c - 1) % 4 + 1) + (c - 1) % 4);
      end
      step();
    end
    req_valid = '0;
    smp();
    check("rot_last", {res_valid, res_id, res_sum}, {1'b1, 2'd0, 32'h100});
    step();
    smp();
    check("drain_hold", {res_valid, res_sum}, {1'b0, 32'h100});

    // Signed overflow on add from requester 2 (pointer is 1).
    set_op(2, 32'h7FFF_FFFF, 32'h1, 1'b0);
    req_valid = 4'b0100;
    smp();
    check("r2_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    smp();
    check("r2_res", {res_valid, res_sum, res_cout, res_ovf, res_id},
          {1'b1, 32'h8000_0000, 1'b0, 1'b1, 2'd2});

    // 3 - 5 from requester 1.
    set_op(1, 32'd3, 32'd5, 1'b1);
    req_valid = 4'b0010;
    smp();
    check("r1_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    smp();
    check("r1_res", {res_valid, res_sum, res_cout, res_ovf, res_id},
          {1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 2'd1});

    // 0x80000000 - 1 from requester 0.
    set_op(0, 32'h8000_0000, 32'h1, 1'b1);
    req_valid = 4'b0001;
    smp();
    check("r0_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    smp();
    check("r0_res", {res_valid, res_sum, res_cout, res_ovf, res_id},
          {1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 2'd0});

    // Fill with 10+20, then hold off the output for three cycles.
    set_op(0, 32'd10, 32'd20, 1'b0);
    req_valid = 4'b0001;
    step();
    set_op(3, 32'hFFFF_FFFF, 32'h1, 1'b0);
    req_valid = 4'b1000;
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      smp();
      check("bp_ready", req_ready, 4'b0000);
      check("bp_hold", {res_valid, res_sum, res_cout, res_ovf, res_id},
            {1'b1, 32'd30, 1'b0, 1'b0, 2'd0});
      step();
    end
    res_ready = 1'b1;
    smp();
    check("bp_release", req_ready, 4'b1000);
    step();
    req_valid = '0;
    smp();
    check("wrap_res", {res_valid, res_sum, res_cout, res_ovf, res_id},
          {1'b1, 32'h0, 1'b1, 1'b0, 2'd3});

    // Move pointer to 2, then reset while full with a request pending.
    set_op(1, 32'd1, 32'd1, 1'b0);
    req_valid = 4'b0010;
    step();
    set_op(2, 32'd7, 32'd2, 1'b1);
    req_valid = 4'b0110;
    res_ready = 1'b0;
    rst_n     = 1'b0;
    smp();
    check("mrst_ready", req_ready, 4'b0000);
    step();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    smp();
    check("mrst_cleared", {res_valid, res_sum, res_cout, res_ovf, res_id}, 0);
    check("mrst_ptr0", req_ready, 4'b0010);
    step();
    req_valid = '0;
    smp();
    check("mrst_after", {res_valid, res_sum, res_id}, {1'b1, 32'd2, 2'd1});
    step();
    step();

    // Random traffic against the reference model.
    hs_prev = '0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || hs_prev[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          set_op(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      smp();
      hs = req_valid & req_ready;
      check("rnd_ready_legal", $onehot0(req_ready) && ((req_ready & ~req_valid) == '0), 1);
      check("rnd_occupancy", res_valid, q.size() != 0);
      if (res_valid && res_ready && q.size() != 0) begin
        e = q.pop_front();
        check("rnd_sum", res_sum, e.sum);
        check("rnd_flags", {res_cout, res_ovf, res_id}, {e.cout, e.ovf, e.id});
      end
      if (hs != '0) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (hs[i]) g = i;
        q.push_back(model(req_a[g*W +: W], req_b[g*W +: W], req_sub[g], g));
        for (int i = 0; i < NREQ; i++) begin
          if (i == g) begin
            check("rnd_starve", wait_cnt[i] <= NREQ - 1, 1);
            wait_cnt[i] = 0;
          end else if (req_valid[i]) begin
            wait_cnt[i]++;
          end
        end
      end
      hs_prev = hs;
      step();
    end

    // Drain the last result.
    req_valid = '0;
    res_ready = 1'b1;
    smp();
    if (res_valid && q.size() != 0) begin
      e = q.pop_front();
      check("drain_sum", {res_sum, res_cout, res_ovf, res_id}, {e.sum, e.cout, e.ovf, e.id});
    end
    step();
    smp();
    check("drain_empty", {res_valid, 32'(q.size())}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
- Shares one 32-bit combinational adder/subtractor among NREQ requesters using round-robin arbitration.
- Each requester presents operands and an add/sub select over a valid/ready handshake.
- The granted operation is computed and captured in a single output register. The result is returned with the requester ID over a second valid/ready handshake.
- Sits between ALU-using agents (e.g. address generator, loop counter, scalar ALU path) and the shared add/sub datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).
- W, 32, operand/result width; fixed at 32 for this revision.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*W  flattened operand A; requester i at [i*W +: W]
- req_b  in  NREQ*W  flattened operand B; same packing
- req_sub  in  NREQ  1 = A-B, 0 = A+B
- res_valid  out  1  result register holds a valid result
- res_ready  in  1  downstream accepts result
- res_sum  out  W  A+B or A-B (two's complement)
- res_cout  out  1  carry out of bit 31; for sub, 1 = no borrow
- res_ovf  out  1  signed overflow
- res_id  out  IDW  index of the requester that produced the result

Behaviour:
- Reset (rst_n=0 at a clk edge) clears the following:
  - res_valid=0; res_sum=0, res_cout=0, res_ovf=0, res_id=0.
  - Round-robin pointer to 0, so requester 0 has highest priority.
  - Any held result is discarded; reset mid-transaction drops it silently.
- Reset overrides all other events in the same cycle.
- Output-register states:
  - EMPTY (res_valid=0) and FULL (res_valid=1).
  - can_accept = !res_valid || res_ready.
- Arbitration, combinational each cycle:
  - If can_accept, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready[grant]=1; all other req_ready bits are 0.
  - If !can_accept or no valid request, req_ready=0.
- req_ready never depends on req_valid of other requesters beyond the priority search.
- Transfer on req_valid[i] && req_ready[i] at clock edge N:
  - Operands of requester i drive the shared datapath.
  - At edge N, res_sum/cout/ovf/id are registered and res_valid=1, visible from cycle N+1.
  - Latency is 1 cycle from request handshake to res_valid.
- ptr <= (grant+1) mod NREQ on every transfer; ptr is unchanged otherwise.
- Back-to-back:
  - If FULL and res_ready=1, the old result pops and a new grant loads in the same edge.
  - Sustained throughput is one operation per cycle.
- FULL and res_ready=0:
  - All res_* outputs hold stable and no grants are issued.
  - Requesters must hold req_valid and operands stable until accepted.
- FULL, res_ready=1, no request: res_valid goes 0 next cycle; res_sum etc. hold their last value.
- Arithmetic:
  - sub=1 computes A + ~B + 1.
  - res_cout is carry out of bit 31.
- Overflow:
  - add: A[31]==B[31] && S[31]!=A[31].
  - sub: A[31]!=B[31] && S[31]!=A[31].
- Wrap-around: 0xFFFFFFFF+1 → sum 0, cout 1, ovf 0.
- NREQ=1 degenerates to a registered handshake stage; ptr stays 0.

Decomposition:
- Package addsub_pkg:
  - ADDSUB_W=32.
  - Op encoding localparams OP_ADD=1'b0, OP_SUB=1'b1.
  - Function for next round-robin pointer.
- One sub-module, addsub_core:
  - Combinational W-bit ripple adder/subtractor.
  - Inputs a, b, sub; outputs sum, cout, ovf.
  - Instantiated once, fed by the granted operand mux.
- Arbiter, mux and output register stay in the top.

Test Plan:
- Reset with req_valid=4'b1111 held → req_ready=0 while rst_n=0, and all res_* = 0. First cycle after reset grants req 0; then grants rotate 1, 2, 3, 0 on consecutive cycles with res_ready=1.
- Req 2 alone: A=0x7FFFFFFF, B=1, add → next cycle res_valid=1, sum=0x80000000, cout=0, ovf=1, id=2.
- Req 1: A=3, B=5, sub → sum=0xFFFFFFFE, cout=0, ovf=0. Req 0: A=0x80000000, B=1, sub → sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: res_ready=0 for 3 cycles while FULL, req 3 valid → req_ready=0 throughout and res_* stable. When res_ready rises, the pop and req 3 grant happen on the same edge, with no bubble.
- Reset asserted while FULL with a pending request → res_valid=0 next cycle, pending request not granted that cycle, ptr=0 afterwards.
- Random: 10k cycles of random valid/operands/res_ready, checked against a reference model. Checks:
  - sum/cout/ovf exact.
  - No lost or duplicated transactions.
  - No requester starved more than NREQ-1 grants.
